// File: rtl/probe_pkg.sv
// Shared types for the probe sweep controller: FSM state encoding and dwell width.
package probe_pkg;

  localparam int DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    SWEEP,
    DONE
  } state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO with registered read port; a push while full is
// accepted only when a pop retires an entry on the same edge.
module trace_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
      if (do_push) begin
        wptr <= wptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wr_data;
    end
  end

endmodule

// File: rtl/probe_sweep_ctrl.sv
// Bring-up controller: pulses the processor reset, sweeps an address range with
// a programmable dwell, and captures the probe bus into a trace FIFO.
module probe_sweep_ctrl
  import probe_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int RST_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [ADDR_W-1:0]      end_addr,
  input  logic [DWELL_W-1:0]     dwell,
  input  logic [DATA_W-1:0]      probe_data,
  output logic                   dut_reset,
  output logic [ADDR_W-1:0]      address,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  end_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [RCW-1:0]     rst_cnt;
  logic               rst_last;
  logic               dwell_last;
  logic               capture;
  logic               fifo_full;
  logic               fifo_empty;
  logic               drop;

  assign rst_last   = (rst_cnt == RCW'(RST_CYCLES - 1));
  assign dwell_last = ((dwell_cnt + DWELL_W'(1)) == dwell_q);
  assign capture    = (state == SWEEP) && dwell_last;
  // A full FIFO still accepts the capture if a real pop frees a slot this edge.
  assign drop       = capture && fifo_full && !(rd_en && !fifo_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RST;
      end
      RST: begin
        busy = 1'b1;
        if (rst_last) state_next = SWEEP;
      end
      SWEEP: begin
        busy = 1'b1;
        if (dwell_last && (address == end_q)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut_reset <= 1'b1;
      address   <= '0;
      end_q     <= '0;
      dwell_q   <= DWELL_W'(1);
      dwell_cnt <= '0;
      rst_cnt   <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dut_reset <= 1'b0;
          if (start) begin
            address   <= start_addr;
            end_q     <= end_addr;
            dwell_q   <= (dwell == '0) ? DWELL_W'(1) : dwell;
            dut_reset <= 1'b1;
            rst_cnt   <= '0;
            overflow  <= 1'b0;
          end
        end
        RST: begin
          rst_cnt <= rst_cnt + RCW'(1);
          if (rst_last) begin
            dut_reset <= 1'b0;
            dwell_cnt <= '0;
          end
        end
        SWEEP: begin
          if (dwell_last) begin
            dwell_cnt <= '0;
            if (address == end_q) begin
              done <= 1'b1;
            end else begin
              address <= address + ADDR_W'(1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
          if (drop) overflow <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  trace_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push    (capture),
    .wr_data (probe_data),
    .pop     (rd_en),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: doc/probe_sweep_ctrl.md
# probe_sweep_ctrl

Parametrised, synthesizable stimulus-and-capture controller for exercising the multicycle processor's instruction memory in bring-up. It pulses the processor reset, then sweeps an address range with a programmable dwell per address, samples a probe bus at the end of each dwell into a trace FIFO, and lets the host drain the trace. It sits beside the processor top in the bring-up harness.

## Interface
Parameters:
- ADDR_W, 8, width of swept address
- DATA_W, 8, width of probe/trace data
- DEPTH, 16, trace FIFO entries (power of two, ≥2)
- RST_CYCLES, 1, cycles dut_reset is held high at sweep start (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a sweep; ignored unless idle
- start_addr  in  ADDR_W  first address, sampled with start
- end_addr  in  ADDR_W  last address, sampled with start
- dwell  in  4  cycles per address, sampled with start; 0 treated as 1
- probe_data  in  DATA_W  processor observation bus (e.g. memdata)
- dut_reset  out  1  reset to processor under test
- address  out  ADDR_W  swept address to processor
- rd_en  in  1  pop one trace entry
- rd_data  out  DATA_W  popped entry
- rd_valid  out  1  rd_data valid this cycle
- count  out  $clog2(DEPTH)+1  entries held
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when sweep completes
- overflow  out  1  sticky: a capture was dropped (FIFO full)

## Operation
- States: IDLE, RST, SWEEP, DONE.
- IDLE: start=1 latches start_addr, end_addr, dwell (0→1); clears overflow; FIFO contents kept. → RST.
- RST: dut_reset=1 for RST_CYCLES cycles, address=start_addr. → SWEEP.
- SWEEP: address held for dwell cycles; on last dwell cycle probe_data pushed to FIFO. If address==end_addr → DONE, else address+1 modulo 2^ADDR_W (end_addr<start_addr wraps through 0; start_addr==end_addr gives one capture).
- DONE: done=1 for one cycle, busy=0. → IDLE. address keeps final value.
- Capture when FIFO full: data dropped, overflow set, sweep continues.
- Push and pop in same cycle: both take effect, count unchanged; pop on empty ignored (rd_valid=0); pop while full plus push: both succeed.
- start while busy: ignored, no latching.
- reset at any time: immediate return to IDLE, FIFO emptied, sweep abandoned.
- Reset values: dut_reset=1 (processor held while controller in reset), address=0, rd_data=0, rd_valid=0, count=0, busy=0, done=0, overflow=0. dut_reset drops to 0 on first clk edge after reset deasserts.
- Sweep length N = ((end_addr−start_addr) mod 2^ADDR_W)+1 addresses; captures = min(N, free entries).

## Timing
- start at edge k → RST occupies edges k+1..k+RST_CYCLES; first address of SWEEP visible after edge k+RST_CYCLES.
- Each address held exactly dwell cycles; capture at the edge ending the dwell, address advances same edge.
- Total busy cycles = RST_CYCLES + N·dwell; done high the following cycle.
- rd_en at edge j → rd_data/rd_valid valid after edge j (registered, 1-cycle latency); count updates same edge.
- busy combinationally = state∈{RST,SWEEP}; all other outputs registered.

## Structure
- Shared package probe_pkg: state enum (IDLE, RST, SWEEP, DONE), DWELL_W=4.
- One sub-module: trace_fifo (synchronous FIFO, DEPTH×DATA_W, push/pop/full/empty/count, async active-high reset) instantiated once; FSM, dwell counter and address counter live in top.

## Test plan
- Basic: start_addr=0, end_addr=3, dwell=2, probe_data=address+8'h10 model → 4 captures 10,11,12,13; done 1+8 cycles after RST end; count=4.
- Wrap: start_addr=FE, end_addr=01, dwell=1 → addresses FE,FF,00,01; captures in that order; N=4.
- Overflow: DEPTH=16, start 0..19, no reads → count=16, overflow=1, entries 0..15 retained; drain gives 0..15 then rd_valid=0.
- Concurrent: rd_en held high during sweep 0..7, dwell=1 → every capture read out once, count ≤1, no overflow.
- Control edge cases: dwell=0 behaves as 1; start pulsed mid-sweep ignored; start_addr==end_addr=5 → one capture.
- Reset mid-sweep at address 3 → outputs return to reset values asynchronously, count=0, dut_reset=1; new start after release runs normally.
